// File: rtl/gba_rom_bridge_pkg.sv
// rtl/gba_rom_bridge_pkg.sv - shared Wishbone widths, ROM base and fetch FSM state for the GBA ROM bridge
package gba_rom_bridge_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam logic [WB_ADR_W-1:0] ROM_BASE_DEFAULT = 32'h0800_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WR
    } fetch_state_t;

    // Word-aligned byte address of the 32-bit word holding GBA halfword hw_addr
    function automatic logic [WB_ADR_W-1:0] rom_word_adr(input logic [WB_ADR_W-1:0] base,
                                                         input logic [23:0] hw_addr);
        logic [WB_ADR_W-1:0] a;
        a = base + {7'd0, hw_addr, 1'b0};
        a[1] = 1'b0;
        return a;
    endfunction

endpackage

// File: rtl/gba_rom_bridge_if.sv
// rtl/gba_rom_bridge_if.sv - Wishbone classic bus between the GBA ROM bridge and the system interconnect
interface gba_rom_bridge_if;
    import gba_rom_bridge_pkg::*;

    logic                cyc_unused_guard;
    logic                wb_cyc;
    logic                wb_stb;
    logic                wb_we;
    logic [WB_ADR_W-1:0] wb_adr;
    logic [3:0]          wb_sel;
    logic [WB_DAT_W-1:0] wb_dat_o;
    logic [WB_DAT_W-1:0] wb_dat_i;
    logic                wb_ack;
    logic                wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o,
        input  wb_dat_i, wb_ack, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o,
        output wb_dat_i, wb_ack, wb_err
    );

endinterface

// File: rtl/gba_rom_bridge_sync_edge.sv
// rtl/gba_rom_bridge_sync_edge.sv - synchronizer with rise/fall pulses for one idle-high GBA control input
module gba_rom_bridge_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // Reset to the idle-high level so release never produces a spurious edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
            last_q <= 1'b1;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign fall = last_q & ~sync_q[SYNC_STAGES-1];
    assign rise = ~last_q & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gba_rom_bridge.sv
// rtl/gba_rom_bridge.sv - GBA cartridge ROM bus to Wishbone read bridge with prefetch FIFO; GBA_ROM_WRITE_EN adds writes
module gba_rom_bridge
    import gba_rom_bridge_pkg::*;
#(
    parameter int                  PREFETCH_DEPTH = 4,
    parameter logic [WB_ADR_W-1:0] ROM_BASE       = ROM_BASE_DEFAULT,
    parameter int                  SYNC_STAGES    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    gba_ncs,
    input  logic                    gba_nrd,
`ifdef GBA_ROM_WRITE_EN
    input  logic                    gba_nwr,
`endif
    input  logic [15:0]             gba_ad_i,
    input  logic [7:0]              gba_a_i,
    output logic [15:0]             gba_ad_o,
    output logic                    gba_ad_oe,
    gba_rom_bridge_if.master        wb,
    output logic                    underrun
);

    localparam int PTR_W = $clog2(PREFETCH_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] PTR_FULL = (PTR_W+1)'(PREFETCH_DEPTH);

    logic ncs_rise, ncs_fall, nrd_rise, nrd_fall;
    logic [15:0]    fifo_mem [PREFETCH_DEPTH];
    logic [PTR_W:0] wr_ptr, rd_ptr, count;
    logic           fifo_empty, fifo_full;
    fetch_state_t   state;
    logic [23:0]    fetch_ptr;
    logic           ncs_low, discard;
    logic           flush, take, push, pop;
    logic [15:0]    push_data;

    gba_rom_bridge_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst(rst), .din(gba_ncs), .rise(ncs_rise), .fall(ncs_fall));
    gba_rom_bridge_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nrd (
        .clk(clk), .rst(rst), .din(gba_nrd), .rise(nrd_rise), .fall(nrd_fall));

`ifdef GBA_ROM_WRITE_EN
    logic        nwr_rise, nwr_fall, wr_pend;
    logic [23:0] haddr, wr_hw;
    logic [15:0] wr_dat;

    gba_rom_bridge_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nwr (
        .clk(clk), .rst(rst), .din(gba_nwr), .rise(nwr_rise), .fall(nwr_fall));
    assign flush = ncs_fall | ncs_rise | nwr_rise;
`else
    assign flush = ncs_fall | ncs_rise;
    assign wb.wb_we    = 1'b0;
    assign wb.wb_dat_o = '0;
`endif

    assign count      = wr_ptr - rd_ptr;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == PTR_FULL);
    assign take       = (state == ST_REQ) && (wb.wb_ack || wb.wb_err);
    // A fetch that overlaps any flush belongs to a stale address and is dropped
    assign push       = take && !discard && !flush;
    assign pop        = nrd_rise && !fifo_empty && !flush;
    assign push_data  = wb.wb_err ? 16'hFFFF :
                        (fetch_ptr[0] ? wb.wb_dat_i[31:16] : wb.wb_dat_i[15:0]);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wb.wb_cyc <= 1'b0;
            wb.wb_stb <= 1'b0;
            wb.wb_adr <= '0;
            wb.wb_sel <= '0;
            fetch_ptr <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ncs_low   <= 1'b0;
            discard   <= 1'b0;
            gba_ad_o  <= '0;
            gba_ad_oe <= 1'b0;
            underrun  <= 1'b0;
`ifdef GBA_ROM_WRITE_EN
            wb.wb_we    <= 1'b0;
            wb.wb_dat_o <= '0;
            haddr       <= '0;
            wr_hw       <= '0;
            wr_dat      <= '0;
            wr_pend     <= 1'b0;
`endif
        end else begin
            if (ncs_fall)      ncs_low <= 1'b1;
            else if (ncs_rise) ncs_low <= 1'b0;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end

            // Only the low 16 bits count, as the GBA's own address counter does
            if (ncs_fall) fetch_ptr <= {gba_a_i, gba_ad_i};
`ifdef GBA_ROM_WRITE_EN
            else if (nwr_rise) fetch_ptr <= {haddr[23:16], haddr[15:0] + 16'd1};
`endif
            else if (push) fetch_ptr <= {fetch_ptr[23:16], fetch_ptr[15:0] + 16'd1};

            if (nrd_fall) begin
                gba_ad_oe <= 1'b1;
                gba_ad_o  <= fifo_empty ? 16'hFFFF : fifo_mem[rd_ptr[PTR_W-1:0]];
                if (fifo_empty) underrun <= 1'b1;
            end
`ifdef GBA_ROM_WRITE_EN
            if (nrd_rise || ncs_rise || nwr_fall) gba_ad_oe <= 1'b0;
            if (ncs_fall) haddr <= {gba_a_i, gba_ad_i};
            else if (nrd_rise || nwr_rise) haddr <= {haddr[23:16], haddr[15:0] + 16'd1};
`else
            if (nrd_rise || ncs_rise) gba_ad_oe <= 1'b0;
`endif

            case (state)
                ST_IDLE: begin
`ifdef GBA_ROM_WRITE_EN
                    if (wr_pend && !flush) begin
                        state       <= ST_WR;
                        wb.wb_cyc   <= 1'b1;
                        wb.wb_stb   <= 1'b1;
                        wb.wb_we    <= 1'b1;
                        wb.wb_adr   <= rom_word_adr(ROM_BASE, wr_hw);
                        wb.wb_sel   <= wr_hw[0] ? 4'b1100 : 4'b0011;
                        wb.wb_dat_o <= {wr_dat, wr_dat};
                    end else
`endif
                    if (ncs_low && !flush && !fifo_full) begin
                        state     <= ST_REQ;
                        wb.wb_cyc <= 1'b1;
                        wb.wb_stb <= 1'b1;
                        wb.wb_adr <= rom_word_adr(ROM_BASE, fetch_ptr);
                        wb.wb_sel <= 4'hF;
                    end
                end
                ST_REQ: begin
                    if (take) begin
                        state     <= ST_IDLE;
                        wb.wb_cyc <= 1'b0;
                        wb.wb_stb <= 1'b0;
                        discard   <= 1'b0;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
`ifdef GBA_ROM_WRITE_EN
                ST_WR: begin
                    if (wb.wb_ack || wb.wb_err) begin
                        state     <= ST_IDLE;
                        wb.wb_cyc <= 1'b0;
                        wb.wb_stb <= 1'b0;
                        wb.wb_we  <= 1'b0;
                        wr_pend   <= 1'b0;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase

`ifdef GBA_ROM_WRITE_EN
            if (nwr_rise) begin
                wr_pend <= 1'b1;
                wr_hw   <= haddr;
                wr_dat  <= gba_ad_i;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gba_rom_bridge.sv
// tb/tb_gba_rom_bridge.sv - directed table-driven bench for gba_rom_bridge with a Wishbone ROM slave model
`timescale 1ns/1ps
module tb_gba_rom_bridge;
    import gba_rom_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        gba_ncs = 1'b1;
    logic        gba_nrd = 1'b1;
    logic [15:0] gba_ad_i = '0;
    logic [7:0]  gba_a_i = '0;
    logic [15:0] gba_ad_o;
    logic        gba_ad_oe;
    logic        underrun;
`ifdef GBA_ROM_WRITE_EN
    logic        gba_nwr = 1'b1;
`endif

    gba_rom_bridge_if wb_bus ();

    gba_rom_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .gba_ncs   (gba_ncs),
        .gba_nrd   (gba_nrd),
`ifdef GBA_ROM_WRITE_EN
        .gba_nwr   (gba_nwr),
`endif
        .gba_ad_i  (gba_ad_i),
        .gba_a_i   (gba_a_i),
        .gba_ad_o  (gba_ad_o),
        .gba_ad_oe (gba_ad_oe),
        .wb        (wb_bus),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          ack_delay = 0;
    bit          err_once = 1'b0;
    bit          cap_first = 1'b0;
    logic [31:0] first_adr = '0;

    // ROM contents: two halfwords pinned for the first vector, the rest derived from the address
    function automatic logic [15:0] hw(input logic [23:0] h);
        if (h == 24'h000010) return 16'hAAAA;
        if (h == 24'h000011) return 16'hBBBB;
        return h[15:0] ^ {h[23:16], h[23:16]} ^ 16'hC3A5;
    endfunction

    initial begin
        logic [31:0] off;
        logic [23:0] h;
        int          wait_cnt;
        wait_cnt = 0;
        wb_bus.wb_ack = 1'b0;
        wb_bus.wb_err = 1'b0;
        wb_bus.wb_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (wb_bus.wb_ack || wb_bus.wb_err) begin
                wb_bus.wb_ack = 1'b0;
                wb_bus.wb_err = 1'b0;
                wait_cnt = 0;
            end else if (wb_bus.wb_cyc && wb_bus.wb_stb) begin
                if (cap_first) begin
                    first_adr = wb_bus.wb_adr;
                    cap_first = 1'b0;
                end
                if (wait_cnt >= ack_delay) begin
                    off = wb_bus.wb_adr - 32'h0800_0000;
                    h = off[24:1];
                    wb_bus.wb_dat_i = {hw(h | 24'h1), hw(h)};
                    if (err_once) begin
                        wb_bus.wb_err = 1'b1;
                        err_once = 1'b0;
                    end else begin
                        wb_bus.wb_ack = 1'b1;
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_cs(input logic [23:0] ha, input int settle);
        @(negedge clk);
        gba_a_i = ha[23:16];
        gba_ad_i = ha[15:0];
        cap_first = 1'b1;
        gba_ncs = 1'b0;
        repeat (settle) @(negedge clk);
    endtask

    task automatic end_cs();
        @(negedge clk);
        gba_ncs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_read(input logic [15:0] exp, input string name);
        @(negedge clk);
        gba_nrd = 1'b0;
        repeat (6) @(negedge clk);
        check({name, "_oe"}, 32'(gba_ad_oe), 32'd1);
        check(name, 32'(gba_ad_o), 32'(exp));
        gba_nrd = 1'b1;
        repeat (6) @(negedge clk);
        check({name, "_oe_off"}, 32'(gba_ad_oe), 32'd0);
    endtask

    task automatic wait_stb_low(input int max_cycles);
        int n;
        n = 0;
        while (wb_bus.wb_stb && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("stb_release", 32'(wb_bus.wb_stb), 32'd0);
    endtask

    typedef struct {
        logic        new_cs;
        logic [23:0] haddr;
        logic [31:0] first_adr;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin
        bit session;
        vecs[0]  = '{1'b1, 24'h000010, 32'h0800_0020, 16'hAAAA};
        vecs[1]  = '{1'b0, 24'h000000, 32'h0,         16'hBBBB};
        vecs[2]  = '{1'b1, 24'h00FFFE, 32'h0801_FFFC, 16'h3C5B};
        vecs[3]  = '{1'b0, 24'h000000, 32'h0,         16'h3C5A};
        vecs[4]  = '{1'b0, 24'h000000, 32'h0,         16'hC3A5};
        vecs[5]  = '{1'b0, 24'h000000, 32'h0,         16'hC3A4};
        vecs[6]  = '{1'b0, 24'h000000, 32'h0,         16'hC3A7};
        vecs[7]  = '{1'b0, 24'h000000, 32'h0,         16'hC3A6};
        vecs[8]  = '{1'b0, 24'h000000, 32'h0,         16'hC3A1};
        vecs[9]  = '{1'b0, 24'h000000, 32'h0,         16'hC3A0};
        vecs[10] = '{1'b1, 24'h123457, 32'h0824_68AC, 16'hE5E0};
        vecs[11] = '{1'b0, 24'h000000, 32'h0,         16'hE5EF};

        repeat (3) @(negedge clk);
        check("rst_oe",       32'(gba_ad_oe),       32'd0);
        check("rst_ad_o",     32'(gba_ad_o),        32'd0);
        check("rst_cyc",      32'(wb_bus.wb_cyc),   32'd0);
        check("rst_stb",      32'(wb_bus.wb_stb),   32'd0);
        check("rst_we",       32'(wb_bus.wb_we),    32'd0);
        check("rst_adr",      wb_bus.wb_adr,        32'd0);
        check("rst_sel",      32'(wb_bus.wb_sel),   32'd0);
        check("rst_dat_o",    wb_bus.wb_dat_o,      32'd0);
        check("rst_underrun", 32'(underrun),        32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        session = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].new_cs) begin
                if (session) end_cs();
                start_cs(vecs[i].haddr, 30);
                check($sformatf("vec%0d_adr", i), first_adr, vecs[i].first_adr);
                session = 1'b1;
            end
            do_read(vecs[i].exp, $sformatf("vec%0d_data", i));
        end
        end_cs();
        check("underrun_clear", 32'(underrun), 32'd0);

        // Underrun while the first fetch is still outstanding, then abort it
        ack_delay = 40;
        start_cs(24'h000100, 3);
        gba_nrd = 1'b0;
        repeat (6) @(negedge clk);
        check("underrun_data", 32'(gba_ad_o), 32'h0000_FFFF);
        check("underrun_oe",   32'(gba_ad_oe), 32'd1);
        check("underrun_flag", 32'(underrun),  32'd1);
        gba_nrd = 1'b1;
        repeat (4) @(negedge clk);
        check("underrun_stb_pending", 32'(wb_bus.wb_stb), 32'd1);
        gba_ncs = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_stb_held", 32'(wb_bus.wb_stb), 32'd1);
        check("abort_cyc_held", 32'(wb_bus.wb_cyc), 32'd1);
        wait_stb_low(100);
        check("underrun_sticky", 32'(underrun), 32'd1);
        repeat (5) @(negedge clk);

        // New nCS while a discarded fetch is pending
        ack_delay = 30;
        start_cs(24'h000300, 8);
        check("pend_stb", 32'(wb_bus.wb_stb), 32'd1);
        gba_ncs = 1'b1;
        repeat (5) @(negedge clk);
        gba_ad_i = 16'h0400;
        gba_ncs = 1'b0;
        repeat (5) @(negedge clk);
        ack_delay = 0;
        repeat (25) @(negedge clk);
        do_read(16'hC7A5, "pend_new0");
        do_read(16'hC7A4, "pend_new1");
        end_cs();

        // Bus error on the first fetch
        err_once = 1'b1;
        start_cs(24'h000500, 30);
        do_read(16'hFFFF, "err_data");
        do_read(16'hC6A4, "err_next");
        end_cs();

        // Asynchronous reset while a fetch is outstanding and oe is driven
        ack_delay = 50;
        start_cs(24'h000600, 8);
        gba_nrd = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_stb", 32'(wb_bus.wb_stb), 32'd1);
        check("mid_oe",  32'(gba_ad_oe),     32'd1);
        #1 rst = 1'b0;
        #1;
        check("arst_cyc",      32'(wb_bus.wb_cyc), 32'd0);
        check("arst_stb",      32'(wb_bus.wb_stb), 32'd0);
        check("arst_oe",       32'(gba_ad_oe),     32'd0);
        check("arst_underrun", 32'(underrun),      32'd0);
        gba_nrd = 1'b1;
        gba_ncs = 1'b1;
        ack_delay = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        do_read(16'hFFFF, "post_rst_empty");
        check("post_rst_underrun", 32'(underrun), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/gba_rom_bridge.md
Name: gba_rom_bridge

Overview:
- Translates the GBA cartridge ROM bus (GBA_nCS / GBA_nRD / GBA_AD / GBA_A) into Wishbone classic read cycles on the system bus.
- Supplies the GBA with halfword data from a prefetch FIFO.
- Sits between the cartridge-edge pins and the shared Wishbone bus that the CPU core also masters; it is the upstream feeder of GBA ROM traffic onto that bus.

Parameters:
- PREFETCH_DEPTH, 4, halfword FIFO entries (power of 2, min 2)
- ROM_BASE, 32'h0800_0000, Wishbone byte address of GBA ROM halfword 0
- SYNC_STAGES, 2, synchronizer flops on GBA control inputs

Ports:
- clk  in  1  system clock (200 MHz)
- rst  in  1  asynchronous, active-low reset
- gba_ncs  in  1  GBA_nCS, async to clk
- gba_nrd  in  1  GBA_nRD, async to clk
- gba_ad_i  in  16  GBA_AD input (low address halfword)
- gba_a_i  in  8  GBA_A input (address bits 23:16)
- gba_ad_o  out  16  read data to GBA_AD
- gba_ad_oe  out  1  GBA_AD output enable
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  write enable (0 unless feature enabled)
- wb_adr  out  32  byte address
- wb_sel  out  4  byte selects
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack  in  1  acknowledge
- wb_err  in  1  error
- underrun  out  1  sticky: GBA read found FIFO empty

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM IDLE; address counter 0.
- Synchronisation: each GBA control input passes through SYNC_STAGES flops plus one edge-detect flop. gba_ad_i and gba_a_i are sampled on the cycle the synced edge is detected (they are stable by then).
- Address latch: on synced nCS falling edge, haddr[23:0] = {gba_a_i, gba_ad_i}. FIFO is flushed and fetch pointer = haddr.
- Fetch FSM:
  - IDLE -> REQ when nCS is low and FIFO has a free slot.
  - REQ: cyc=stb=1, adr = ROM_BASE + {fetch_ptr, 1'b0} with bit 1 cleared, sel=4'hF.
  - On ack: push halfword dat_i[31:16] if fetch_ptr[0] else dat_i[15:0]. fetch_ptr += 1, wrapping only in the low 16 bits (bits 23:16 held, matching GBA counter behaviour). Go to IDLE.
  - On err: push 16'hFFFF, then behave as on ack.
  - Exactly one outstanding Wishbone transaction at a time.
- GBA read:
  - On synced nRD falling: gba_ad_oe=1 and gba_ad_o = FIFO head. If the FIFO is empty, drive 16'hFFFF and set underrun.
  - On synced nRD rising: pop head if non-empty; gba_ad_oe=0 in the same cycle.
- nCS rising: oe=0; flush FIFO. If in REQ, hold cyc/stb until ack/err, then discard the data.
- nCS falling while a discarded fetch is still pending: new haddr is latched; the new fetch starts only after the pending ack.
- Simultaneous push and pop: both occur; count unchanged.
- Full FIFO: FSM stays IDLE.
- underrun clears only on reset.

Optional Feature:
- GBA_ROM_WRITE_EN defined:
  - Adds input gba_nwr (synced like nrd).
  - On synced nWR rising: FIFO is flushed; one Wishbone write is issued with adr per the read rule, sel = 4'b1100 if haddr[0] else 4'b0011, dat_o = {gba_ad_i, gba_ad_i}.
  - haddr increments; prefetch resumes after ack.
- Undefined: port absent, wb_we tied 0, wb_dat_o tied 0.

Decomposition:
- Shared wishbone package: ROM_BASE default, WB_ADR_W=32, WB_DAT_W=32, fetch FSM state enum.
- Sub-module sync_edge: synchronizer plus rise/fall pulse outputs, instantiated per GBA control input.
- FIFO stays inline.

Test Plan:
- Single read: nCS falls with A=8'h00, AD=16'h0010. Slave returns 32'h BBBB_AAAA at byte 0x0800_0020. First nRD pulse -> gba_ad_o=16'hAAAA; second nRD pulse -> 16'hBBBB from the 0x0800_0020 word (halfword 0x11).
- Sequential burst: 8 nRD pulses from haddr 24'h00_FFFE -> addresses wrap to 24'h00_0000 (not 24'h01_0000); data correct.
- Underrun: slave ack delayed 40 cycles, nRD falls immediately -> gba_ad_o=16'hFFFF, underrun=1, stays 1 after nCS rises.
- Abort: nCS rises while stb=1 -> cyc/stb held until ack, data discarded. Next nCS with a new address returns correct data.
- Error: wb_err on first fetch -> GBA sees 16'hFFFF; next halfword correct.
- Reset mid-fetch: rst low during REQ -> cyc/stb/oe drop asynchronously; FIFO empty after release.
